// File: rtl/sdpb_double_buffer.sv
// Ping-pong frame buffer: two simple-dual-port RAM banks whose ownership swaps via commit/release.
// Define SDPB_DB_OUT_REG_EN to add an output register on rd_data/rd_valid (read latency 2).

module sdpb_double_buffer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_commit,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_avail,
  input  logic              rd_release,
  output logic              drop_err,
  output logic [15:0]       swap_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state, state_n;
  logic   wb, wb_n;
  logic   avail_n;
  logic   swap;
  logic   wr_fire, rd_fire, release_ok;

  logic [DATA_W-1:0] bank0 [DEPTH];
  logic [DATA_W-1:0] bank1 [DEPTH];

  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  assign wr_ready   = (state == FILL);
  assign wr_fire    = wr_en & wr_ready;
  assign rd_fire    = rd_en & rd_avail;
  assign release_ok = rd_release & rd_avail;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    state_n = state;
    avail_n = rd_avail;
    swap    = 1'b0;
    case (state)
      FILL: begin
        if (wr_commit) begin
          // Reader idle or releasing this same cycle: the new frame can go straight over.
          if (!rd_avail || release_ok) begin
            swap    = 1'b1;
            avail_n = 1'b1;
          end else begin
            state_n = HOLD;
          end
        end else if (release_ok) begin
          avail_n = 1'b0;
        end
      end
      HOLD: begin
        if (release_ok) begin
          swap    = 1'b1;
          state_n = FILL;
        end
      end
      default: state_n = FILL;
    endcase
  end

  assign wb_n = wb ^ swap;

  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: non-blocking assignments make every register here sample pre-edge values.
    if (!resetn) begin
      state    <= FILL;
      wb       <= 1'b0;
      rd_avail <= 1'b0;
      swap_cnt <= '0;
      drop_err <= 1'b0;
    end else begin
      state    <= state_n;
      wb       <= wb_n;
      rd_avail <= avail_n;
      if (swap)
        swap_cnt <= swap_cnt + 16'd1;
      if (!wr_ready && (wr_en || wr_commit))
        drop_err <= 1'b1;
    end
  end

  // NOTE: the RAM arrays are deliberately left without reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_fire && !wb)
      bank0[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (wr_fire && wb)
      bank1[wr_addr] <= wr_data;
  end

  // Read bank is ~wb sampled at issue, so a read in a swap cycle still sees the old frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_fire)
        rd_data_q <= wb ? bank0[rd_addr] : bank1[rd_addr];
    end
  end

`ifdef SDPB_DB_OUT_REG_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_valid_q;
      if (rd_valid_q)
        rd_data <= rd_data_q;
    end
  end
`else
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
`endif

endmodule

// File: tb/tb_sdpb_double_buffer.sv
// Self-checking bench for sdpb_double_buffer: frame-level model plus directed literal checks.

module tb_sdpb_double_buffer;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef SDPB_DB_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_commit = 1'b0;
  logic              wr_ready;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_avail;
  logic              rd_release = 1'b0;
  logic              drop_err;
  logic [15:0]       swap_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  sdpb_double_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_commit  (wr_commit),
    .wr_ready   (wr_ready),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_avail   (rd_avail),
    .rd_release (rd_release),
    .drop_err   (drop_err),
    .swap_cnt   (swap_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Model: the writer's frame and the reader's frame as plain arrays that trade places on a swap.
  typedef struct packed {
    logic              v;
    logic [DATA_W-1:0] d;
  } rd_ent_t;

  logic [DATA_W-1:0] wframe [DEPTH];
  logic [DATA_W-1:0] rframe [DEPTH];
  rd_ent_t           pipe [LAT];
  logic              m_hold, m_avail, m_drop, m_valid;
  logic [15:0]       m_swaps;
  logic [DATA_W-1:0] m_data;

  task automatic model_swap();
    for (int i = 0; i < DEPTH; i++) begin
      logic [DATA_W-1:0] t;
      t         = wframe[i];
      wframe[i] = rframe[i];
      rframe[i] = t;
    end
    m_swaps = m_swaps + 16'd1;
  endtask

  task automatic model_update();
    rd_ent_t e;
    logic    rel;
    if (!resetn) begin
      m_hold  = 1'b0;
      m_avail = 1'b0;
      m_drop  = 1'b0;
      m_valid = 1'b0;
      m_swaps = '0;
      m_data  = '0;
      for (int i = 0; i < LAT; i++) pipe[i] = '0;
    end else begin
      e.v = rd_en && m_avail;
      e.d = rframe[rd_addr];
      for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = e;
      m_valid = pipe[LAT-1].v;
      if (m_valid) m_data = pipe[LAT-1].d;
      if (wr_en && !m_hold) wframe[wr_addr] = wr_data;
      if (m_hold && (wr_en || wr_commit)) m_drop = 1'b1;
      rel = rd_release && m_avail;
      if (!m_hold) begin
        if (wr_commit) begin
          if (!m_avail || rel) begin
            model_swap();
            m_avail = 1'b1;
          end else begin
            m_hold = 1'b1;
          end
        end else if (rel) begin
          m_avail = 1'b0;
        end
      end else if (rel) begin
        model_swap();
        m_hold = 1'b0;
      end
    end
  endtask

  always @(posedge clk or negedge resetn) model_update();

  always @(negedge clk) begin
    check("cyc_wr_ready", 64'(wr_ready), 64'(!m_hold));
    check("cyc_rd_avail", 64'(rd_avail), 64'(m_avail));
    check("cyc_rd_valid", 64'(rd_valid), 64'(m_valid));
    check("cyc_rd_data",  64'(rd_data),  64'(m_data));
    check("cyc_drop_err", 64'(drop_err), 64'(m_drop));
    check("cyc_swap_cnt", 64'(swap_cnt), 64'(m_swaps));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(a);
    wr_data = DATA_W'(d);
    step();
    wr_en   = 1'b0;
  endtask

  task automatic commit();
    wr_commit = 1'b1;
    step();
    wr_commit = 1'b0;
  endtask

  task automatic release_bank();
    rd_release = 1'b1;
    step();
    rd_release = 1'b0;
  endtask

  task automatic read_one(input string name, input int a, input int exp_data);
    rd_en   = 1'b1;
    rd_addr = ADDR_W'(a);
    step();
    rd_en   = 1'b0;
    repeat (LAT - 1) step();
    check({name, "_valid"}, 64'(rd_valid), 64'd1);
    check({name, "_data"},  64'(rd_data),  64'(DATA_W'(exp_data)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t exceeded budget 1000000", $time);
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    check("rst_wr_ready", 64'(wr_ready), 64'd1);
    check("rst_rd_avail", 64'(rd_avail), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_rd_data",  64'(rd_data),  64'd0);
    check("rst_swap_cnt", 64'(swap_cnt), 64'd0);
    resetn = 1'b1;
    step();

    // Frame 1: data = addr + 0x100, then stream it back.
    for (int a = 0; a < DEPTH; a++) write_word(a, 32'h100 + a);
    commit();
    check("f1_rd_avail", 64'(rd_avail), 64'd1);
    check("f1_swap_cnt", 64'(swap_cnt), 64'd1);
    for (int a = 0; a < DEPTH; a++) begin
      rd_en   = 1'b1;
      rd_addr = ADDR_W'(a);
      step();
    end
    rd_en = 1'b0;
    repeat (LAT) step();
    read_one("f1_a3", 3, 32'h103);
    read_one("f1_a511", 511, 32'h2FF);

    // Frame 2 committed while frame 1 is unreleased: writer holds.
    for (int a = 0; a < DEPTH; a++) write_word(a, 32'h200 + a);
    commit();
    check("hold_wr_ready", 64'(wr_ready), 64'd0);
    read_one("hold_a7", 7, 32'h107);
    write_word(5, 32'hDEAD);
    check("hold_drop_err", 64'(drop_err), 64'd1);
    release_bank();
    check("rel_swap_cnt", 64'(swap_cnt), 64'd2);
    check("rel_wr_ready", 64'(wr_ready), 64'd1);
    read_one("rel_a5", 5, 32'h205);

    // Commit and release together: immediate swap, frame stays available.
    for (int a = 0; a < 4; a++) write_word(a, 32'h300 + a);
    wr_commit  = 1'b1;
    rd_release = 1'b1;
    step();
    wr_commit  = 1'b0;
    rd_release = 1'b0;
    check("cr_swap_cnt", 64'(swap_cnt), 64'd3);
    check("cr_rd_avail", 64'(rd_avail), 64'd1);
    check("cr_wr_ready", 64'(wr_ready), 64'd1);
    read_one("cr_a2", 2, 32'h302);
    read_one("cr_a10", 10, 32'h10A);

    // Release alone: nothing to read, a read is refused and rd_data holds.
    release_bank();
    check("idle_rd_avail", 64'(rd_avail), 64'd0);
    rd_en   = 1'b1;
    rd_addr = '0;
    step();
    rd_en   = 1'b0;
    repeat (LAT - 1) step();
    check("idle_rd_valid", 64'(rd_valid), 64'd0);
    check("idle_rd_data",  64'(rd_data),  64'h10A);

    // Read issued in a swap cycle returns the old bank; write+commit lands before the swap.
    write_word(0, 32'h400);
    commit();
    check("sw_swap_cnt4", 64'(swap_cnt), 64'd4);
    wr_en      = 1'b1;
    wr_addr    = '0;
    wr_data    = 32'h500;
    wr_commit  = 1'b1;
    rd_release = 1'b1;
    rd_en      = 1'b1;
    rd_addr    = '0;
    step();
    wr_en      = 1'b0;
    wr_commit  = 1'b0;
    rd_release = 1'b0;
    rd_en      = 1'b0;
    repeat (LAT - 1) step();
    check("sw_rd_valid", 64'(rd_valid), 64'd1);
    check("sw_rd_data",  64'(rd_data),  64'h400);
    check("sw_swap_cnt5", 64'(swap_cnt), 64'd5);
    read_one("sw_new_a0", 0, 32'h500);

    // Reset in HOLD with a read in flight.
    commit();
    check("rh_wr_ready", 64'(wr_ready), 64'd0);
    rd_en   = 1'b1;
    rd_addr = '0;
    step();
    rd_en   = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    check("rh_rd_valid", 64'(rd_valid), 64'd0);
    check("rh_rd_data",  64'(rd_data),  64'd0);
    check("rh_swap_cnt", 64'(swap_cnt), 64'd0);
    check("rh_wr_ready", 64'(wr_ready), 64'd1);
    check("rh_rd_avail", 64'(rd_avail), 64'd0);
    check("rh_drop_err", 64'(drop_err), 64'd0);
    step();
    resetn = 1'b1;
    step();
    write_word(9, 32'h909);
    commit();
    check("post_swap_cnt", 64'(swap_cnt), 64'd1);
    check("post_rd_avail", 64'(rd_avail), 64'd1);
    read_one("post_a9", 9, 32'h909);

    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sdpb_double_buffer.md
Name: sdpb_double_buffer

Overview:
- Parametrised single-clock ping-pong frame buffer built from two inferred simple-dual-port RAM banks.
- The writer (HDMI capture side) fills one bank while the reader (matrix output side) reads the other completed bank.
- Ownership swaps through a commit/release handshake, so a bank is never read while it is half written.
- Replaces fixed 32x512 hand-instantiated SDPB primitives with generic width/depth and frame-level flow control.

Parameters:
- DATA_W, 32, word width in bits (1..64)
- ADDR_W, 9, per-bank address width; depth per bank = 2**ADDR_W words

Ports:
- clk  in  1  single clock for both ports
- resetn  in  1  asynchronous active-low reset
- wr_en  in  1  write strobe; honoured only when wr_ready=1
- wr_addr  in  ADDR_W  write address within the current write bank
- wr_data  in  DATA_W  write data
- wr_commit  in  1  pulse: the write bank holds a complete frame
- wr_ready  out  1  writer may write or commit
- rd_en  in  1  read strobe
- rd_addr  in  ADDR_W  read address within the current read bank
- rd_data  out  DATA_W  read data
- rd_valid  out  1  rd_data is valid this cycle
- rd_avail  out  1  the read bank holds a committed frame
- rd_release  in  1  pulse: the reader has finished with the read bank
- drop_err  out  1  sticky: a write or commit was issued while wr_ready=0
- swap_cnt  out  16  number of bank swaps since reset, wraps at 2**16

Behaviour:
- State: wb (write bank index, 1 bit); read bank = ~wb. FSM states are FILL and HOLD.
- Reset values: wb=0, FSM=FILL, wr_ready=1, rd_avail=0, rd_valid=0, rd_data=0, drop_err=0, swap_cnt=0. RAM contents are not cleared.
- FILL (wr_ready=1):
  - wr_en writes wr_data into bank wb at wr_addr on the clock edge.
  - wr_commit with rd_avail=0 swaps: wb toggles, rd_avail is 1 next cycle, stay in FILL.
  - wr_commit with rd_avail=1 and rd_release=0 goes to HOLD.
  - wr_commit with rd_avail=1 and rd_release=1 in the same cycle swaps immediately; rd_avail stays 1 because a new frame is now present.
  - rd_release without commit clears rd_avail next cycle.
- HOLD (wr_ready=0):
  - The writer is blocked.
  - rd_release swaps: wb toggles, rd_avail stays 1, return to FILL, wr_ready is 1 next cycle.
- wr_en together with wr_commit in the same cycle: the write lands in the committing bank before the swap.
- Writes and commits while wr_ready=0 are dropped and set drop_err. drop_err clears only on reset.
- rd_release while rd_avail=0 is ignored.
- Each swap increments swap_cnt by 1; it wraps from 0xFFFF to 0.
- Read latency is 1 cycle. rd_en at cycle N with rd_avail=1 gives rd_data and rd_valid=1 at N+1.
  - The bank select is captured at issue: a read issued in the same cycle as a swap returns data from the old bank.
  - rd_en while rd_avail=0 gives rd_valid=0 at N+1; rd_data holds its previous value.
- Reads and writes always target different banks, so there is no read/write collision.
- Reset asserted mid-operation returns everything to its reset values immediately (asynchronous). An in-flight read is discarded, with rd_valid=0.

Optional Feature:
- SDPB_DB_OUT_REG_EN defined: an extra output pipeline register is added on rd_data/rd_valid, giving read latency 2 (better Fmax, maps to the BRAM output register). The bank select is still captured at issue.
- Not defined: read latency 1 as specified above.

Test Plan:
- Reset, write addr 0..511 with data = addr+0x100, commit, read 0..511 -> rd_avail=1 one cycle after commit, rd_data = addr+0x100, rd_valid 1 cycle after each rd_en (2 with macro), swap_cnt=1.
- Commit a second frame (data = addr+0x200) while the first is unreleased -> wr_ready=0 (HOLD), reads still return +0x100. rd_release -> swap_cnt=2, wr_ready=1, reads return +0x200.
- In HOLD, pulse wr_en to addr 5 with 0xDEAD -> drop_err=1, and after release addr 5 reads 0x205.
- Same-cycle wr_commit and rd_release with rd_avail=1 -> immediate swap, rd_avail stays 1, FSM remains in FILL.
- rd_en with rd_avail=0 -> rd_valid=0. rd_en issued in the swap cycle -> data comes from the previous bank.
- Deassert resetn during HOLD with a read in flight -> all outputs at reset values, rd_valid=0, swap_cnt=0, and a new write/commit cycle works normally.
